alu_muldiv: RTL
===============

Name: alu_muldiv

Overview:
Parametrised iterative multiply/divide unit for the RV core. It is the sequential successor to the combinational ALU and implements the full RV32M/RV64M op set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It uses one shift-add / restoring shift-subtract step per clock and connects to the execute stage through valid/ready handshakes on both input and output. Its 3-bit flags output is formatted like the ALU's so that the writeback muxing stays uniform.

Parameters:
XLEN, 32, operand/result width; legal values 32 or 64.
CNTW, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
clk  input  1  core clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operation request.
in_ready  output  1  unit can accept a request (high only in IDLE).
op  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
a  input  XLEN  rs1 operand.
b  input  XLEN  rs2 operand.
flush  input  1  synchronous abort (pipeline kill).
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
out  output  XLEN  result.
flags  output  3  {divzero, negative, zero} of the result.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out=0, flags=0, out_valid=0, in_ready=1 once rst_n is high; internal counter and registers cleared. Assertion mid-operation discards the operation with no output.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1.
  - in_valid=1 at a clock edge latches op, a and b.
  - Signed ops latch operand magnitudes plus sign bits. MULHSU treats a as signed and b as unsigned.
  - Normal ops go to CALC with counter=0.
  - Special division cases go directly to DONE with the result computed combinationally from the latched operands:
    - b==0: DIV/DIVU out = all ones, REM/REMU out = a, divzero=1.
    - Signed overflow (DIV/REM with a = most-negative and b = -1): DIV out = a, REM out = 0, divzero=0.
- CALC: one iteration per edge. The counter increments and the state leaves for FIX when counter reaches XLEN-1.
  - Multiply: 2*XLEN-bit product built by shift-add.
  - Divide: XLEN-bit quotient and remainder built by restoring division.
- FIX: one cycle to apply signs, then go to DONE.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - Result selection: MUL takes product[XLEN-1:0]; MULH/MULHSU/MULHU take product[2XLEN-1:XLEN].
- DONE: out_valid=1; out and flags are held stable while out_ready=0.
  - out_ready=1 at an edge returns to IDLE. out_valid drops the next cycle.
  - No same-cycle re-accept: a new request is possible at the earliest one cycle after the handshake.
- Latency, counted from the accepting edge:
  - Normal ops: out_valid is first high after XLEN+1 further edges (XLEN CALC + 1 FIX; 33 cycles at XLEN=32).
  - Special divide cases: out_valid is high in the cycle immediately after the accepting edge.
- flags:
  - zero = (out==0).
  - negative = out[XLEN-1].
  - divzero = 1 only for DIV/DIVU/REM/REMU with b==0.
  - All three are registered together with out.
- flush=1 at an edge forces IDLE from any state and takes priority over in_valid and out_ready. out_valid=0 the next cycle; out and flags keep their old values but are invalid.
- in_valid while not in IDLE is ignored; the source must hold the request until in_ready.
- Operands a, b and op may change after acceptance without affecting the operation in progress.

Test Plan:
- MUL a=0x00000007, b=0xFFFFFFFD (-3), XLEN=32 -> out=0xFFFFFFEB, flags=010, out_valid after exactly 33 edges from acceptance.
- MULH a=b=0x80000000 -> out=0x40000000, flags=000. MULHU with the same operands -> 0x40000000. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF, flags=010.
- DIVU a=0x12345678, b=0 -> out=0xFFFFFFFF, flags=110, out_valid 1 cycle after acceptance. REM a=0x12345678, b=0 -> out=0x12345678, flags=100.
- DIV a=0x80000000, b=0xFFFFFFFF -> out=0x80000000, flags=010. REM with the same operands -> 0, flags=001. REM a=-7, b=2 -> 0xFFFFFFFF. DIV a=-7, b=2 -> 0xFFFFFFFD.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out, flags and out_valid stable, in_ready=0. Release -> IDLE next cycle, then accept a new op.
- Flush at CALC iteration 5 -> out_valid never rises, in_ready=1 next cycle, and a following DIVU 100/7 gives 14 with correct latency. Repeat with rst_n pulsed low mid-CALC -> outputs zero immediately.

Source files
------------

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative RV32M/RV64M multiply/divide unit with valid/ready handshakes
//
// Purpose: one shift-add (multiply) or restoring shift-subtract (divide) step
// per clock. Signed operands are converted to magnitudes on acceptance, and
// signs are reapplied in a single FIX cycle. Division by zero and signed
// overflow bypass the iteration and complete in one cycle.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  request handshake (in_ready high only in IDLE)
//   op                  funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   a, b                rs1 / rs2 operands
//   flush               synchronous abort, returns to IDLE from any state
//   out_valid, out_ready result handshake
//   out                 result
//   flags               {divzero, negative, zero} of out, registered with out

module alu_muldiv #(
    parameter int XLEN = 32,
    parameter int CNTW = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out,
    output logic [2:0]      flags
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t              state;
    logic [CNTW-1:0]     cnt;
    logic [2:0]          op_r;
    logic                sign_a;
    logic                sign_b;
    // Multiplicand magnitude for multiplies, divisor magnitude for divides.
    logic [XLEN-1:0]     opnd;
    // Shared working register: {hi, lo}.
    // Multiply: hi = partial product, lo = multiplier shifting out LSB-first.
    // Divide:   hi = partial remainder, lo = dividend shifting out MSB-first
    //           while quotient bits shift in at the bottom.
    logic [2*XLEN-1:0]   acc;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    assign in_ready = (state == S_IDLE);

    // ------------------------------------------------------------------
    // Request decode (IDLE only)
    // ------------------------------------------------------------------
    logic            a_signed;
    logic            b_signed;
    logic            sa_in;
    logic            sb_in;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            b_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_res;

    always_comb begin
        // Divides: op[0]=1 is unsigned. Multiplies: MULHU unsigned in both,
        // MULHSU signed rs1 only. MUL low half is sign-agnostic.
        a_signed    = op[2] ? ~op[0] : (op[1:0] != 2'b11);
        b_signed    = op[2] ? ~op[0] : ~op[1];
        sa_in       = a_signed & a[XLEN-1];
        sb_in       = b_signed & b[XLEN-1];
        // The most-negative value negates to itself, which is the correct
        // unsigned magnitude.
        mag_a       = sa_in ? (~a + 1'b1) : a;
        mag_b       = sb_in ? (~b + 1'b1) : b;
        b_zero      = (b == '0);
        div_ovf     = op[2] & ~op[0] & (a == MOST_NEG) & (&b);
        special     = op[2] & (b_zero | div_ovf);
        special_res = '0;
        if (b_zero) begin
            special_res = op[1] ? a : '1;
        end else if (div_ovf) begin
            special_res = op[1] ? '0 : a;
        end
    end

    // ------------------------------------------------------------------
    // One iteration step
    // ------------------------------------------------------------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN:0]     div_diff;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_diff  = div_shift - {1'b0, opnd};
        // The remainder is always below the divisor, so XLEN bits suffice.
        div_rem   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        div_next  = {div_rem, acc[XLEN-2:0], div_ge};
    end

    // ------------------------------------------------------------------
    // Sign fix-up and result selection (FIX)
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        prod_s = (sign_a ^ sign_b) ? (~acc + 1'b1) : acc;
        quo_s  = (sign_a ^ sign_b) ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
        rem_s  = sign_a ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
        case (op_r)
            3'b000:                 fix_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo_s;
            default:                fix_res = rem_s;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op_r      <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            opnd      <= '0;
            acc       <= '0;
            out       <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            // out/flags keep their stale values; out_valid marks them invalid.
            state     <= S_IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_r   <= op;
                        sign_a <= sa_in;
                        sign_b <= sb_in;
                        cnt    <= '0;
                        if (special) begin
                            out       <= special_res;
                            flags     <= {b_zero, special_res[XLEN-1], special_res == '0};
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            opnd  <= op[2] ? mag_b : mag_a;
                            acc   <= {{XLEN{1'b0}}, (op[2] ? mag_a : mag_b)};
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc <= op_r[2] ? div_next : mul_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNTW'(XLEN - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    out       <= fix_res;
                    flags     <= {1'b0, fix_res[XLEN-1], fix_res == '0};
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
